// File: rtl/fdc_sector_bridge_pkg.sv
// Shared constants, FSM state encoding and the JV1 drive/track/sector to linear-sector map.
// Linear sector = track*sectors_per_track + sector; two linear sectors share one 512-byte LBA.
package fdc_sector_bridge_pkg;

  localparam int SECT_PER_TRK_DEF = 10;
  localparam int NUM_DRIVES_DEF   = 2;
  localparam int TIMEOUT_W        = 24;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_REQ,
    RD_XFER,
    WR_REQ,
    WR_XFER,
    DONE,
    ERR
  } state_t;

  function automatic logic [10:0] sector_lin(input logic [6:0] track,
                                             input logic [3:0] sector,
                                             input int spt);
    return 11'(int'(track) * spt + int'(sector));
  endfunction

endpackage

// File: rtl/fdc_sector_bridge_if.sv
// hps_io SD block port. The bridge is the master (issues block requests);
// hps_io is the slave (acknowledges and streams 16-bit words).
interface fdc_sector_bridge_if #(
  parameter int NUM_DRIVES = 2
);
  logic [31:0]           sd_lba;
  logic [NUM_DRIVES-1:0] sd_rd;
  logic [NUM_DRIVES-1:0] sd_wr;
  logic                  sd_ack;
  logic [7:0]            sd_buff_addr;
  logic [15:0]           sd_buff_dout;
  logic [15:0]           sd_buff_din;
  logic                  sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/fdc_sector_bridge_sector_dpram.sv
// 512x8 true dual-port RAM: port A 8-bit bytes, port B 16-bit byte-enabled words (low byte = even byte).
// Both read ports are registered (1-cycle latency); no backpressure.
module sector_dpram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  a_addr,
  input  logic [7:0]  a_din,
  input  logic        a_we,
  output logic [7:0]  a_dout,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_be,
  output logic [15:0] b_dout
);

  // Split into even/odd byte banks so port B touches both bytes of a word at once.
  logic [7:0] mem_even [256];
  logic [7:0] mem_odd  [256];

  always_ff @(posedge clk) begin
    if (a_we) begin
      if (a_addr[0]) mem_odd[a_addr[8:1]]  <= a_din;
      else           mem_even[a_addr[8:1]] <= a_din;
    end
    if (b_be[0]) mem_even[b_addr] <= b_din[7:0];
    if (b_be[1]) mem_odd[b_addr]  <= b_din[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= a_addr[0] ? mem_odd[a_addr[8:1]] : mem_even[a_addr[8:1]];
      b_dout <= {mem_odd[b_addr], mem_even[b_addr]};
    end
  end

endmodule

// File: rtl/fdc_sector_bridge.sv
// Moves 256-byte JV1 sectors between the FDC buffer port and 512-byte hps_io SD blocks.
// Reads fetch the enclosing block; writes read the block, merge the FDC half and write it back.
module fdc_sector_bridge
  import fdc_sector_bridge_pkg::*;
#(
  parameter int SECT_PER_TRK = SECT_PER_TRK_DEF,
  parameter int NUM_DRIVES   = NUM_DRIVES_DEF,
  parameter int TMO_W        = TIMEOUT_W
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NUM_DRIVES-1:0] img_mounted,
  input  logic [63:0]           img_size,
  input  logic                  drive,
  input  logic [6:0]            track,
  input  logic [3:0]            sector,
  input  logic                  rd_req,
  input  logic                  wr_req,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [7:0]            buf_addr,
  input  logic [7:0]            buf_din,
  input  logic                  buf_we,
  output logic [7:0]            buf_dout,
  fdc_sector_bridge_if.master   sd
);

  state_t state, state_nx;

  logic             drv_q;
  logic [10:0]      lin_q;
  logic             bad_sect_q;
  logic             wr_op_q;
  logic             abort_q;
  logic             err_q;
  logic             ack_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [63:0]      img_size_q [NUM_DRIVES];

  logic [10:0] lin_now;
  logic [63:0] cur_size;
  logic [63:0] need_bytes;
  logic        req_go;
  logic        ack_fall;
  logic        tmo_hit;
  logic        fdc_half;
  logic        b_we;

  assign lin_now    = sector_lin(track, sector, SECT_PER_TRK);
  assign cur_size   = img_size_q[drv_q];
  assign need_bytes = {44'd0, {1'b0, lin_q} + 12'd1, 8'd0};
  assign req_go     = (state == IDLE) && (rd_req || wr_req);
  assign ack_fall   = ack_q && !sd.sd_ack;
  assign tmo_hit    = &tmo_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = err_q;
    sd.sd_rd  = '0;
    sd.sd_wr  = '0;
    unique case (state)
      IDLE: begin
        if (rd_req || wr_req) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (bad_sect_q || abort_q || cur_size == 64'd0 || need_bytes > cur_size)
          state_nx = ERR;
        else
          state_nx = RD_REQ;
      end
      RD_REQ: begin
        busy     = 1'b1;
        sd.sd_rd = NUM_DRIVES'(1) << drv_q;
        if (sd.sd_ack)               state_nx = RD_XFER;
        else if (abort_q || tmo_hit) state_nx = ERR;
      end
      RD_XFER: begin
        busy = 1'b1;
        if (ack_fall) state_nx = abort_q ? ERR : (wr_op_q ? WR_REQ : DONE);
      end
      WR_REQ: begin
        busy     = 1'b1;
        sd.sd_wr = NUM_DRIVES'(1) << drv_q;
        if (sd.sd_ack)               state_nx = WR_XFER;
        else if (abort_q || tmo_hit) state_nx = ERR;
      end
      WR_XFER: begin
        busy = 1'b1;
        if (ack_fall) state_nx = abort_q ? ERR : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      drv_q      <= 1'b0;
      lin_q      <= '0;
      bad_sect_q <= 1'b0;
      wr_op_q    <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      tmo_cnt    <= '0;
      for (int i = 0; i < NUM_DRIVES; i++) img_size_q[i] <= '0;
    end else begin
      ack_q   <= sd.sd_ack;
      tmo_cnt <= (state == RD_REQ || state == WR_REQ) ? tmo_cnt + 1'b1 : '0;
      for (int i = 0; i < NUM_DRIVES; i++)
        if (img_mounted[i]) img_size_q[i] <= img_size;
      if (req_go) begin
        drv_q      <= drive;
        lin_q      <= lin_now;
        bad_sect_q <= ({28'd0, sector} >= 32'(SECT_PER_TRK));
        wr_op_q    <= !rd_req;
        err_q      <= 1'b0;
        abort_q    <= 1'b0;
      end else begin
        if (state == ERR) err_q <= 1'b1;
        // A remount under an active transfer invalidates it; finish the SD cycle, then fail.
        if (busy && img_mounted[drv_q]) abort_q <= 1'b1;
      end
    end
  end

  assign sd.sd_lba = {22'd0, lin_q[10:1]};

  // Reads keep the selected half; writes keep the other half so the FDC's new bytes survive.
  assign b_we = sd.sd_buff_wr && sd.sd_ack && (state == RD_REQ || state == RD_XFER) &&
                ((sd.sd_buff_addr[7] == lin_q[0]) != wr_op_q);

  // When idle the FDC addresses the half of the sector it has currently selected.
  assign fdc_half = busy ? lin_q[0] : lin_now[0];

  sector_dpram u_ram (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .a_addr ({fdc_half, buf_addr}),
    .a_din  (buf_din),
    .a_we   (buf_we),
    .a_dout (buf_dout),
    .b_addr (sd.sd_buff_addr),
    .b_din  (sd.sd_buff_dout),
    .b_be   ({2{b_we}}),
    .b_dout (sd.sd_buff_din)
  );

endmodule

// File: tb/tb_fdc_sector_bridge.sv
// Directed + randomized bench: a byte-array disk image model plays hps_io and predicts every transfer.
module tb_fdc_sector_bridge;

  localparam int SPT   = 10;
  localparam int TMO_W = 10;
  localparam int IMG0  = 89600;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  img_mounted = '0;
  logic [63:0] img_size = '0;
  logic        drive = 1'b0;
  logic [6:0]  track = '0;
  logic [3:0]  sector = '0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic        busy, done, err;
  logic [7:0]  buf_addr = '0;
  logic [7:0]  buf_din = '0;
  logic        buf_we = 1'b0;
  logic [7:0]  buf_dout;

  fdc_sector_bridge_if #(.NUM_DRIVES(2)) sd ();

  fdc_sector_bridge #(.SECT_PER_TRK(SPT), .NUM_DRIVES(2), .TMO_W(TMO_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .drive       (drive),
    .track       (track),
    .sector      (sector),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .buf_addr    (buf_addr),
    .buf_din     (buf_din),
    .buf_we      (buf_we),
    .buf_dout    (buf_dout),
    .sd          (sd)
  );

  always #5 clk_sys = ~clk_sys;

  int npass = 0;
  int ntotal = 0;

  logic [7:0]      disk [2][IMG0];
  longint unsigned size_m [2];
  logic [7:0]      fdc_data [256];
  logic [15:0]     wr_got [256];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit op_ok(input int d, input int t, input int s);
    longint unsigned need;
    need = longint'(t * SPT + s + 1) * 256;
    return (s < SPT) && (size_m[d] != 0) && (need <= size_m[d]);
  endfunction

  task automatic mount(input int d, input longint unsigned sz);
    img_size    = sz;
    img_mounted = 2'(1 << d);
    tick();
    img_mounted = '0;
    size_m[d]   = sz;
  endtask

  task automatic fdc_wr(input int a, input logic [7:0] v);
    buf_addr = 8'(a);
    buf_din  = v;
    buf_we   = 1'b1;
    tick();
    buf_we   = 1'b0;
  endtask

  task automatic fdc_rd(input int a, output logic [7:0] v);
    buf_addr = 8'(a);
    tick();
    v = buf_dout;
  endtask

  // kind: 0 = no SD request (done came first or budget expired), 1 = read, 2 = write
  task automatic wait_sd(output int kind, output int bits, output longint lba);
    kind = 0; bits = 0; lba = 0;
    for (int i = 0; i < 64; i++) begin
      if (|sd.sd_rd)      begin kind = 1; bits = int'(sd.sd_rd); lba = longint'(sd.sd_lba); break; end
      else if (|sd.sd_wr) begin kind = 2; bits = int'(sd.sd_wr); lba = longint'(sd.sd_lba); break; end
      else if (done) break;
      tick();
    end
  endtask

  task automatic serve_read(input int d, input int lba);
    int base;
    base = lba * 512;
    sd.sd_ack = 1'b1;
    tick();
    for (int w = 0; w < 256; w++) begin
      sd.sd_buff_addr = 8'(w);
      sd.sd_buff_dout = {disk[d][base + 2*w + 1], disk[d][base + 2*w]};
      sd.sd_buff_wr   = 1'b1;
      tick();
    end
    sd.sd_buff_wr = 1'b0;
    sd.sd_ack     = 1'b0;
    tick();
  endtask

  task automatic serve_write();
    sd.sd_ack = 1'b1;
    tick();
    for (int w = 0; w < 256; w++) begin
      sd.sd_buff_addr = 8'(w);
      tick();
      wr_got[w] = sd.sd_buff_din;
    end
    sd.sd_ack = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit seen, output bit e);
    seen = 1'b0; e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin seen = 1'b1; e = err; break; end
      tick();
    end
  endtask

  task automatic check_buffer(input string tag, input int d, input int lin);
    int nbad;
    logic [7:0] v;
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      fdc_rd(i, v);
      if (v !== disk[d][lin*256 + i]) nbad++;
    end
    check(tag, nbad, 0);
  endtask

  task automatic run_op(input bit is_wr, input int d, input int t, input int s);
    int lin, lba, h, kind, bits, nbad, b;
    longint lba_o;
    bit ok, seen, e;
    logic [7:0] lo, hi;
    lin = t * SPT + s;
    lba = lin / 2;
    h   = lin % 2;
    ok  = op_ok(d, t, s);
    drive = d[0]; track = 7'(t); sector = 4'(s);
    if (is_wr) for (int i = 0; i < 256; i++) fdc_wr(i, fdc_data[i]);
    rd_req = !is_wr; wr_req = is_wr;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    wait_sd(kind, bits, lba_o);
    if (!ok) begin
      check("no_sd_req", kind, 0);
    end else begin
      check("rd_kind", kind, 1);
      check("rd_drv", bits, 1 << d);
      check("rd_lba", lba_o, lba);
      serve_read(d, lba);
      if (is_wr) begin
        wait_sd(kind, bits, lba_o);
        check("wr_kind", kind, 2);
        check("wr_drv", bits, 1 << d);
        check("wr_lba", lba_o, lba);
        serve_write();
        nbad = 0;
        for (int w = 0; w < 256; w++) begin
          b  = 2 * w;
          lo = ((b >> 8) == h) ? fdc_data[b & 255] : disk[d][lba*512 + b];
          hi = (((b+1) >> 8) == h) ? fdc_data[(b+1) & 255] : disk[d][lba*512 + b + 1];
          if (wr_got[w] !== {hi, lo}) nbad++;
        end
        check("wr_block", nbad, 0);
        for (int i = 0; i < 256; i++) disk[d][lin*256 + i] = fdc_data[i];
      end
    end
    wait_done(64, seen, e);
    check("done", seen, 1);
    check("err", e, !ok);
    check("busy_at_done", busy, 0);
    tick();
    if (ok && !is_wr) check_buffer("rd_data", d, lin);
  endtask

  initial begin
    int kind, bits, n, nd;
    longint lba_o;
    bit seen, e, sw;

    sd.sd_ack = 1'b0; sd.sd_buff_addr = '0; sd.sd_buff_dout = '0; sd.sd_buff_wr = 1'b0;
    size_m[0] = 0; size_m[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < IMG0; i++) disk[d][i] = 8'($urandom);

    // reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_sd_rd", sd.sd_rd, 0);
    check("rst_sd_wr", sd.sd_wr, 0);
    check("rst_sd_lba", sd.sd_lba, 0);
    check("rst_buff_din", sd.sd_buff_din, 0);
    check("rst_buf_dout", buf_dout, 0);
    reset_n = 1'b1;
    tick();

    // 1: upper-half read of LBA 17
    mount(0, IMG0);
    run_op(0, 0, 3, 5);
    // 2: sector out of range
    run_op(0, 0, 0, 10);
    // 3: write merges FDC half into LBA 0
    for (int i = 0; i < 256; i++) fdc_data[i] = 8'hA5;
    run_op(1, 0, 0, 1);
    run_op(0, 0, 0, 0);
    run_op(0, 0, 0, 1);
    // 4: no image on drive 1, then mount it
    run_op(0, 1, 2, 3);
    mount(1, longint'($urandom_range(40, 350)) * 256);
    run_op(0, 1, 2, 3);

    // randomized mix of reads and writes
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 256; i++) fdc_data[i] = 8'($urandom);
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1),
             $urandom_range(0, 39), $urandom_range(0, 15));
    end

    // 5a: no acknowledge -> timeout
    drive = 1'b0; track = 7'd1; sector = 4'd0;
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    wait_sd(kind, bits, lba_o);
    check("tmo_kind", kind, 1);
    n = 0;
    while (!done && n < (1 << TMO_W) + 64) begin tick(); n++; end
    check("tmo_done", done, 1);
    check("tmo_err", err, 1);
    check("tmo_window", (n >= (1 << TMO_W) - 2) && (n <= (1 << TMO_W) + 2), 1);
    check("tmo_drop", sd.sd_rd, 0);
    tick();

    // 5b: reset in the middle of a read transfer
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    wait_sd(kind, bits, lba_o);
    check("mid_kind", kind, 1);
    sd.sd_ack = 1'b1; tick();
    for (int w = 0; w < 10; w++) begin
      sd.sd_buff_addr = 8'(w); sd.sd_buff_dout = 16'($urandom); sd.sd_buff_wr = 1'b1; tick();
    end
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_sd_rd", sd.sd_rd, 0);
    check("arst_sd_wr", sd.sd_wr, 0);
    check("arst_sd_lba", sd.sd_lba, 0);
    check("arst_buff_din", sd.sd_buff_din, 0);
    check("arst_buf_dout", buf_dout, 0);
    sd.sd_buff_wr = 1'b0; sd.sd_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    size_m[0] = 0; size_m[1] = 0;
    tick();
    run_op(0, 0, 1, 0);
    mount(0, IMG0);

    // 6: simultaneous requests read only; request while busy ignored
    drive = 1'b0; track = 7'd2; sector = 4'd7;
    rd_req = 1'b1; wr_req = 1'b1; tick(); rd_req = 1'b0; wr_req = 1'b0;
    wait_sd(kind, bits, lba_o);
    check("both_kind", kind, 1);
    check("both_lba", lba_o, 13);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    serve_read(0, 13);
    nd = 0; sw = 1'b0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin nd++; e = err; end
      if (|sd.sd_wr || |sd.sd_rd) sw = 1'b1;
      tick();
    end
    check("both_done_cnt", nd, 1);
    check("both_no_req", sw, 0);
    check("both_err", e, 0);
    check_buffer("both_data", 0, 27);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
